// File: rtl/dmem_lsu_ram.sv
// dmem_lsu_ram: byte-addressable data memory for the MEM stage. It supports byte-lane
// stores, a registered read, and RISC-V load sign/zero extension with fault flagging.
module dmem_lsu_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  localparam int NB    = DATA_WIDTH / 8,
  localparam int OFF   = $clog2(NB),
  localparam int DEPTH = 1 << ADDR_WIDTH
) (
  input  logic                      CLK,
  input  logic                      RESET_N,
  input  logic [ADDR_WIDTH+OFF-1:0] daddr,
  input  logic                      MemRead,
  input  logic                      MemWrite,
  input  logic [2:0]                funct3,
  input  logic [DATA_WIDTH-1:0]     ddata_w,
  output logic [DATA_WIDTH-1:0]     ddata_r,
  output logic                      rvalid,
  output logic                      access_fault
);

  if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_width
    $error("dmem_lsu_ram: DATA_WIDTH must be 32 or 64");
  end

  logic [ADDR_WIDTH-1:0] idx;
  logic [OFF-1:0]        off;
  logic [OFF-1:0]        mask;
  logic                  illegal;
  logic                  misalign;
  logic                  fault;
  logic                  wr_en;
  logic                  rd_en;
  logic [NB-1:0]         be;
  logic [DATA_WIDTH-1:0] wdata_sh;
  logic [DATA_WIDTH-1:0] raw_word;

  assign idx = daddr[ADDR_WIDTH+OFF-1:OFF];
  assign off = daddr[OFF-1:0];

  // mask = access size - 1; an access is aligned when off has no bits inside it
  always_comb begin
    mask = '0;
    case (funct3[1:0])
      2'b00:   mask = '0;
      2'b01:   mask = OFF'(3'd1);
      2'b10:   mask = OFF'(3'd3);
      default: mask = OFF'(3'd7);
    endcase
  end

  assign illegal  = (funct3 == 3'b111) ||
                    ((DATA_WIDTH == 32) && ((funct3 == 3'b011) || (funct3 == 3'b110)));
  assign misalign = |(off & mask);
  assign fault    = (MemRead | MemWrite) & (illegal | misalign);
  assign wr_en    = RESET_N & MemWrite & ~fault;
  assign rd_en    = MemRead & ~fault;
  assign wdata_sh = ddata_w << {off, 3'b000};

  // One byte-wide RAM per lane; each read port is registered and is read-first
  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    localparam logic [OFF-1:0] LANE = OFF'(gi);
    logic [7:0] mem_q [DEPTH];
    logic [7:0] rd_q;

    assign be[gi] = ((LANE & ~mask) == off);

    always_ff @(posedge CLK) begin
      if (wr_en && be[gi]) begin
        mem_q[idx] <= wdata_sh[gi*8 +: 8];
      end
      rd_q <= mem_q[idx];
    end

    assign raw_word[gi*8 +: 8] = rd_q;

`ifndef SYNTHESIS
    a_store_lane: assert property (@(posedge CLK) disable iff (!RESET_N)
      (wr_en && be[gi]) |=> (mem_q[$past(idx)] == $past(wdata_sh[gi*8 +: 8])));
`endif
  end

  logic                  load_q;
  logic                  fault_q;
  logic                  rfault_q;
  logic [OFF-1:0]        off_q;
  logic [2:0]            f3_q;
  logic [DATA_WIDTH-1:0] hold_q;
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] ext;
  logic [DATA_WIDTH-1:0] rdata_d;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      load_q   <= 1'b0;
      fault_q  <= 1'b0;
      rfault_q <= 1'b0;
      off_q    <= '0;
      f3_q     <= 3'b000;
      hold_q   <= '0;
    end else begin
      load_q   <= rd_en;
      fault_q  <= fault;
      rfault_q <= fault & MemRead;
      if (rd_en) begin
        off_q <= off;
        f3_q  <= funct3;
      end
      hold_q <= rdata_d;
    end
  end

  assign shifted = raw_word >> {off_q, 3'b000};

  always_comb begin
    ext = shifted;
    case (f3_q)
      3'b000:  ext = DATA_WIDTH'($signed(shifted[7:0]));
      3'b001:  ext = DATA_WIDTH'($signed(shifted[15:0]));
      3'b010:  ext = DATA_WIDTH'($signed(shifted[31:0]));
      3'b100:  ext = DATA_WIDTH'(shifted[7:0]);
      3'b101:  ext = DATA_WIDTH'(shifted[15:0]);
      3'b110:  ext = DATA_WIDTH'(shifted[31:0]);
      default: ext = shifted;
    endcase
  end

  // A faulting load zeroes the result; a faulting store or idle cycle keeps it
  always_comb begin
    rdata_d = hold_q;
    if (rfault_q) begin
      rdata_d = '0;
    end else if (load_q) begin
      rdata_d = ext;
    end
  end

  assign ddata_r      = rdata_d;
  assign rvalid       = load_q;
  assign access_fault = fault_q;

`ifndef SYNTHESIS
  a_rvalid_past_read: assert property (@(posedge CLK) disable iff (!RESET_N)
    rvalid |-> $past(MemRead));
  a_rvalid_fault_excl: assert property (@(posedge CLK) disable iff (!RESET_N)
    !(rvalid && access_fault));
`endif

endmodule

// File: tb/tb_dmem_lsu_ram.sv
// Scoreboard bench for dmem_lsu_ram: drives a 32-bit and a 64-bit instance and
// compares each cycle's rvalid/access_fault/ddata_r against queued expectations.
`timescale 1ns/1ps
module tb_dmem_lsu_ram;

  localparam logic [2:0] F_B  = 3'b000;
  localparam logic [2:0] F_H  = 3'b001;
  localparam logic [2:0] F_W  = 3'b010;
  localparam logic [2:0] F_D  = 3'b011;
  localparam logic [2:0] F_BU = 3'b100;
  localparam logic [2:0] F_HU = 3'b101;
  localparam logic [2:0] F_WU = 3'b110;
  localparam logic [2:0] F_X  = 3'b111;

  logic        CLK = 1'b0;
  logic        RESET_N;

  logic [11:0] a32;
  logic        rd32, wr32;
  logic [2:0]  f3_32;
  logic [31:0] wd32, rdat32;
  logic        rv32, flt32;

  logic [12:0] a64;
  logic        rd64, wr64;
  logic [2:0]  f3_64;
  logic [63:0] wd64, rdat64;
  logic        rv64, flt64;

  always #5 CLK = ~CLK;

  dmem_lsu_ram #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) u_dut32 (
    .CLK(CLK), .RESET_N(RESET_N), .daddr(a32), .MemRead(rd32), .MemWrite(wr32),
    .funct3(f3_32), .ddata_w(wd32), .ddata_r(rdat32), .rvalid(rv32), .access_fault(flt32)
  );

  dmem_lsu_ram #(.DATA_WIDTH(64), .ADDR_WIDTH(10)) u_dut64 (
    .CLK(CLK), .RESET_N(RESET_N), .daddr(a64), .MemRead(rd64), .MemWrite(wr64),
    .funct3(f3_64), .ddata_w(wd64), .ddata_r(rdat64), .rvalid(rv64), .access_fault(flt64)
  );

  typedef struct {
    bit          w64;
    bit          rv;
    bit          flt;
    logic [63:0] d;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [63:0] last32;
  logic [63:0] last64;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic set_idle();
    a32 = '0; rd32 = 1'b0; wr32 = 1'b0; f3_32 = 3'b000; wd32 = '0;
    a64 = '0; rd64 = 1'b0; wr64 = 1'b0; f3_64 = 3'b000; wd64 = '0;
  endtask

  task automatic drive(input string tag, input bit w64, input bit rd, input bit wr,
                       input logic [2:0] f3, input logic [12:0] a, input logic [63:0] wd,
                       input bit erv, input bit eflt);
    exp_t e;
    @(negedge CLK);
    set_idle();
    if (w64) begin
      a64 = a; rd64 = rd; wr64 = wr; f3_64 = f3; wd64 = wd;
    end else begin
      a32 = a[11:0]; rd32 = rd; wr32 = wr; f3_32 = f3; wd32 = wd[31:0];
    end
    e.w64 = w64;
    e.rv  = erv;
    e.flt = eflt;
    e.d   = w64 ? last64 : last32;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic store(input string tag, input bit w64, input logic [2:0] f3,
                       input logic [12:0] a, input logic [63:0] wd);
    drive(tag, w64, 1'b0, 1'b1, f3, a, wd, 1'b0, 1'b0);
  endtask

  task automatic load(input string tag, input bit w64, input logic [2:0] f3,
                      input logic [12:0] a, input logic [63:0] exp);
    if (w64) last64 = exp; else last32 = exp;
    drive(tag, w64, 1'b1, 1'b0, f3, a, 64'd0, 1'b1, 1'b0);
  endtask

  task automatic bad(input string tag, input bit w64, input bit rd, input bit wr,
                     input logic [2:0] f3, input logic [12:0] a);
    if (rd) begin
      if (w64) last64 = '0; else last32 = '0;
    end
    drive(tag, w64, rd, wr, f3, a, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
  endtask

  task automatic idle(input string tag, input bit w64);
    drive(tag, w64, 1'b0, 1'b0, 3'b000, 13'd0, 64'd0, 1'b0, 1'b0);
  endtask

  // Monitor: one transaction per cycle, popped shortly after the active edge
  initial begin
    exp_t        e;
    logic [63:0] act_d;
    logic        act_rv, act_flt;
    forever begin
      @(posedge CLK);
      #2;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        if (e.w64) begin
          act_d = rdat64; act_rv = rv64; act_flt = flt64;
        end else begin
          act_d = {32'd0, rdat32}; act_rv = rv32; act_flt = flt32;
        end
        $display("TXN %-18s w64=%0b rvalid=%0b fault=%0b ddata_r=%h", e.tag, e.w64,
                 act_rv, act_flt, act_d);
        chk({e.tag, ".rvalid"}, 64'(act_rv), 64'(e.rv));
        chk({e.tag, ".fault"}, 64'(act_flt), 64'(e.flt));
        chk({e.tag, ".data"}, act_d, e.d);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, scoreboard depth %0d", sb.size());
    $fatal(1, "timeout");
  end

  initial begin
    last32  = '0;
    last64  = '0;
    RESET_N = 1'b0;
    set_idle();
    repeat (3) @(posedge CLK);
    #1;
    chk("reset.rvalid32", 64'(rv32), 64'd0);
    chk("reset.fault32", 64'(flt32), 64'd0);
    chk("reset.data32", 64'(rdat32), 64'd0);
    chk("reset.rvalid64", 64'(rv64), 64'd0);
    chk("reset.fault64", 64'(flt64), 64'd0);
    chk("reset.data64", rdat64, 64'd0);
    @(negedge CLK);
    RESET_N = 1'b1;

    // Word store then back-to-back load
    store("sw_deadbeef", 1'b0, F_W, 13'h010, 64'hDEAD_BEEF);
    load("lw_deadbeef", 1'b0, F_W, 13'h010, 64'hDEAD_BEEF);
    idle("idle_hold", 1'b0);

    // Byte lane 3 plus sign/zero extension
    store("sw_zero_010", 1'b0, F_W, 13'h010, 64'h0);
    store("sb_80", 1'b0, F_B, 13'h013, 64'h1234_5680);
    load("lb_013", 1'b0, F_B, 13'h013, 64'hFFFF_FF80);
    load("lbu_013", 1'b0, F_BU, 13'h013, 64'h0000_0080);
    load("lw_010", 1'b0, F_W, 13'h010, 64'h8000_0000);

    // Halfword and misalignment
    store("sw_zero_020", 1'b0, F_W, 13'h020, 64'h0);
    store("sh_1234", 1'b0, F_H, 13'h022, 64'hABCD_1234);
    load("lh_022", 1'b0, F_H, 13'h022, 64'h0000_1234);
    bad("sh_mis_021", 1'b0, 1'b0, 1'b1, F_H, 13'h021);
    load("lw_020_kept", 1'b0, F_W, 13'h020, 64'h1234_0000);
    bad("lw_mis_022", 1'b0, 1'b1, 1'b0, F_W, 13'h022);
    idle("idle_after_flt", 1'b0);
    store("sh_8001", 1'b0, F_H, 13'h024, 64'h0000_8001);
    load("lh_024", 1'b0, F_H, 13'h024, 64'hFFFF_8001);
    load("lhu_024", 1'b0, F_HU, 13'h024, 64'h0000_8001);

    // Encodings that are illegal at 32 bits
    bad("ld_on32", 1'b0, 1'b1, 1'b0, F_D, 13'h000);
    bad("lwu_on32", 1'b0, 1'b1, 1'b0, F_WU, 13'h000);
    store("sw_after_flt", 1'b0, F_W, 13'h030, 64'hCAFE_F00D);
    bad("st_f3_111", 1'b0, 1'b0, 1'b1, F_X, 13'h030);
    load("lw_030", 1'b0, F_W, 13'h030, 64'hCAFE_F00D);

    // Read-first collision
    store("sw_1111", 1'b0, F_W, 13'h040, 64'h1111_1111);
    last32 = 64'h1111_1111;
    drive("rw_collide", 1'b0, 1'b1, 1'b1, F_W, 13'h040, 64'h2222_2222, 1'b1, 1'b0);
    load("lw_040_new", 1'b0, F_W, 13'h040, 64'h2222_2222);

    // Reset with a load in flight; a store during reset is dropped
    load("ld_inflight", 1'b0, F_W, 13'h010, 64'h8000_0000);
    @(posedge CLK);
    #3;
    RESET_N = 1'b0;
    #1;
    chk("async_rst.rvalid", 64'(rv32), 64'd0);
    chk("async_rst.data", 64'(rdat32), 64'd0);
    chk("async_rst.fault", 64'(flt32), 64'd0);
    last32 = '0;
    last64 = '0;
    store("sw_in_reset", 1'b0, F_W, 13'h010, 64'h5555_5555);
    idle("reset_idle", 1'b0);
    RESET_N = 1'b1;
    load("lw_010_kept", 1'b0, F_W, 13'h010, 64'h8000_0000);

    // 64-bit instance
    store("sd_0123", 1'b1, F_D, 13'h008, 64'h0123_4567_89AB_CDEF);
    load("ld_008", 1'b1, F_D, 13'h008, 64'h0123_4567_89AB_CDEF);
    load("lw_00c", 1'b1, F_W, 13'h00C, 64'h0000_0000_0123_4567);
    load("lwu_00c", 1'b1, F_WU, 13'h00C, 64'h0000_0000_0123_4567);
    load("lw_008", 1'b1, F_W, 13'h008, 64'hFFFF_FFFF_89AB_CDEF);
    load("lwu_008", 1'b1, F_WU, 13'h008, 64'h0000_0000_89AB_CDEF);
    load("lb_00f", 1'b1, F_B, 13'h00F, 64'h0000_0000_0000_0001);
    load("lh_00e", 1'b1, F_H, 13'h00E, 64'h0000_0000_0000_0123);
    bad("f3_111_64", 1'b1, 1'b1, 1'b0, F_X, 13'h008);
    bad("ld_mis_00c", 1'b1, 1'b1, 1'b0, F_D, 13'h00C);
    store("sb_lane5", 1'b1, F_B, 13'h00D, 64'h0000_0000_0000_00A5);
    load("ld_008_b", 1'b1, F_D, 13'h008, 64'h0123_A567_89AB_CDEF);

    @(negedge CLK);
    set_idle();
    repeat (3) @(posedge CLK);
    #5;
    chk("sb_drain", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_lsu_ram.md
Name: dmem_lsu_ram

Overview:
Byte-addressable data memory with a registered read path for the pipelined core's MEM stage.
- Successor to the word-only registered RAM. Adds byte/halfword/word (and doubleword at 64-bit) stores via byte-lane enables, and RISC-V load sign/zero extension.
- Flags misaligned or illegal accesses, and signals read validity.
- Sits between the EX/MEM pipeline register and the MEM/WB register. Load data is valid one cycle after issue.

Parameters:
- DATA_WIDTH, 32, word width in bits. Legal values are 32 and 64 only; any other value is an elaboration error.
- ADDR_WIDTH, 10, word-index bits. Depth is 2**ADDR_WIDTH words.
- Derived: NB = DATA_WIDTH/8; OFF = log2(NB).

Ports:
- CLK, input, 1: rising-edge clock.
- RESET_N, input, 1: reset, asynchronous, active-low.
- daddr, input, ADDR_WIDTH+OFF: byte address. Word index is daddr[ADDR_WIDTH+OFF-1:OFF]; lane offset is daddr[OFF-1:0].
- MemRead, input, 1: load request this cycle.
- MemWrite, input, 1: store request this cycle.
- funct3, input, 3: access size and sign, RISC-V encoding. 000 B, 001 H, 010 W, 011 D (64-bit only), 100 BU, 101 HU, 110 WU (64-bit only).
- ddata_w, input, DATA_WIDTH: store data, right-aligned (bits [size-1:0] used).
- ddata_r, output, DATA_WIDTH: load result, extended, registered.
- rvalid, output, 1: high the cycle after an accepted load.
- access_fault, output, 1: high the cycle after a faulting request.

Behaviour:
- Clock and reset: one clock, CLK. Reset RESET_N is asynchronous and active-low.
- Reset values: ddata_r=0, rvalid=0, access_fault=0.
  - Array contents are not reset. At simulation start all words are 0.
  - While RESET_N is low, no write occurs and no load is accepted.
  - Asserting reset with a load in flight clears rvalid immediately; the result is discarded.
- Access size S: 1 byte for B/BU, 2 for H/HU, 4 for W/WU, 8 for D.
- Fault when any of:
  - funct3 is 011 or 110 with DATA_WIDTH=32;
  - funct3 is 111;
  - daddr mod S != 0.
  - Fault check applies only when MemRead or MemWrite is high.
- Store, MemWrite=1 with no fault, at the rising edge:
  - Lanes [off, off+S-1] of the addressed word take ddata_w bytes [0..S-1].
  - All other lanes are unchanged.
- Faulting store: no lane is written. access_fault=1 next cycle.
- Load, MemRead=1 with no fault, at edge N:
  - Raw word, lane offset and funct3 are captured.
  - At edge N+1, ddata_r takes the selected bytes, sign-extended (B, H, W) or zero-extended (BU, HU, WU). D passes through.
  - rvalid=1 for exactly that one cycle.
  - Latency is 1 cycle from request to data; throughput is one load per cycle.
- Faulting load: ddata_r=0, rvalid=0, access_fault=1 on the next cycle.
- No request (MemRead=0): ddata_r holds its last value, rvalid=0.
- access_fault is 0 on any cycle following a non-faulting or idle cycle.
- MemRead and MemWrite both high, same address: write is performed; read returns pre-write contents (read-first).
  - The following cycle's read sees the new data.
- Back-to-back store then load to the same word: the load sees the stored bytes. No bypass is required beyond array ordering.
- Address wrap: not applicable. The word index covers exactly the full depth.
- Concurrent assertions (simulation only):
  - After a non-faulting store, the addressed lanes equal the past data.
  - rvalid implies that the past MemRead was high.
  - rvalid and access_fault are never both high.

Test Plan:
1. Word store/load (32-bit): SW 0xDEADBEEF at daddr 0x010, then LW 0x010. Next cycle: ddata_r=0xDEADBEEF, rvalid=1.
2. Byte lanes plus extension: SB 0x80 at 0x013 over word 0x00000000, then:
   - LB 0x013 gives 0xFFFFFF80;
   - LBU 0x013 gives 0x00000080;
   - LW 0x010 gives 0x80000000.
3. Halfword and misalignment:
   - SH 0x1234 at 0x022, then LH 0x022 gives 0x00001234.
   - SH at 0x021 gives access_fault=1, word unchanged.
   - LW at 0x022 gives access_fault=1, rvalid=0, ddata_r=0.
4. Read-first collision: word 0x040 holds 0x11111111. In one cycle, MemRead=MemWrite=1, SW 0x22222222 at 0x040. Next cycle: ddata_r=0x11111111. A subsequent LW returns 0x22222222.
5. Reset mid-operation:
   - Issue LW, then drop RESET_N before the next edge. rvalid, ddata_r and access_fault go to 0 immediately.
   - A SW issued during reset leaves memory unchanged.
6. DATA_WIDTH=64:
   - SD 0x0123456789ABCDEF at 0x008; LW 0x00C gives 0x0000000001234567; LWU gives the same value.
   - funct3=111 gives access_fault=1.
